// File: rtl/qspi_req_arb.sv
// qspi_req_arb: arbitrates an instruction-fetch port and a data port onto a
// single downstream read/write command interface, with round-robin contention
// handling and a per-transaction response timeout.
module qspi_req_arb #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    // fetch port
    input  logic        if_req,
    input  logic [31:0] if_adr,
    output logic        if_valid,
    output logic [31:0] if_data,
    // data port
    input  logic        d_rd_req,
    input  logic        d_wr_req,
    input  logic        d_w,
    input  logic        d_hw,
    input  logic [31:0] d_adr,
    input  logic [31:0] d_wdata,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic        d_finish,
    output logic        err,
    // downstream read command / response
    output logic        read_req,
    output logic        read_w,
    output logic        read_hw,
    output logic [31:0] read_adr,
    input  logic        read_valid,
    input  logic [31:0] read_data,
    // downstream write command / completion
    output logic        write_req,
    output logic        write_w,
    output logic        write_hw,
    output logic [31:0] write_adr,
    output logic [31:0] write_data,
    input  logic        write_finish
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_t;

    localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic        r_last_d;   // 1 = data port was granted last
    logic        r_own_d;    // owner of the transaction in flight (1 = data)

    logic        r_if_valid;
    logic [31:0] r_if_data;
    logic        r_d_valid;
    logic [31:0] r_d_rdata;
    logic        r_d_finish;
    logic        r_err;

    logic        r_read_req;
    logic        r_read_w;
    logic        r_read_hw;
    logic [31:0] r_read_adr;
    logic        r_write_req;
    logic        r_write_w;
    logic        r_write_hw;
    logic [31:0] r_write_adr;
    logic [31:0] r_write_data;

    logic        w_d_req;
    logic        w_pulse;
    logic        w_grant_d;
    logic        w_grant_f;
    logic        w_timeout;

    // A response pulse in flight blocks granting so a still-held request
    // level from the master just served is not re-granted.
    assign w_d_req   = d_rd_req | d_wr_req;
    assign w_pulse   = r_if_valid | r_d_valid | r_d_finish;
    assign w_grant_d = w_d_req & (~if_req | ~r_last_d);
    assign w_grant_f = if_req & ~w_grant_d;
    assign w_timeout = (r_cnt == TO_CNT);

    assign if_valid   = r_if_valid;
    assign if_data    = r_if_data;
    assign d_valid    = r_d_valid;
    assign d_rdata    = r_d_rdata;
    assign d_finish   = r_d_finish;
    assign err        = r_err;
    assign read_req   = r_read_req;
    assign read_w     = r_read_w;
    assign read_hw    = r_read_hw;
    assign read_adr   = r_read_adr;
    assign write_req  = r_write_req;
    assign write_w    = r_write_w;
    assign write_hw   = r_write_hw;
    assign write_adr  = r_write_adr;
    assign write_data = r_write_data;

    // Arbitration FSM: grant, issue one-cycle command pulse, wait for response or timeout.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= 8'd0;
            r_last_d     <= 1'b0;
            r_own_d      <= 1'b0;
            r_if_valid   <= 1'b0;
            r_if_data    <= 32'd0;
            r_d_valid    <= 1'b0;
            r_d_rdata    <= 32'd0;
            r_d_finish   <= 1'b0;
            r_err        <= 1'b0;
            r_read_req   <= 1'b0;
            r_read_w     <= 1'b0;
            r_read_hw    <= 1'b0;
            r_read_adr   <= 32'd0;
            r_write_req  <= 1'b0;
            r_write_w    <= 1'b0;
            r_write_hw   <= 1'b0;
            r_write_adr  <= 32'd0;
            r_write_data <= 32'd0;
        end else begin
            r_read_req  <= 1'b0;
            r_write_req <= 1'b0;
            r_if_valid  <= 1'b0;
            r_d_valid   <= 1'b0;
            r_d_finish  <= 1'b0;
            r_err       <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_pulse) begin
                        if (w_grant_d) begin
                            r_last_d <= 1'b1;
                            r_own_d  <= 1'b1;
                            r_cnt    <= 8'd0;
                            if (d_wr_req) begin
                                r_write_adr  <= d_adr;
                                r_write_data <= d_wdata;
                                r_write_w    <= d_w;
                                r_write_hw   <= d_hw;
                                r_write_req  <= 1'b1;
                                r_state      <= WR_WAIT;
                            end else begin
                                r_read_adr <= d_adr;
                                r_read_w   <= d_w;
                                r_read_hw  <= d_hw;
                                r_read_req <= 1'b1;
                                r_state    <= RD_WAIT;
                            end
                        end else if (w_grant_f) begin
                            r_last_d   <= 1'b0;
                            r_own_d    <= 1'b0;
                            r_cnt      <= 8'd0;
                            r_read_adr <= if_adr;
                            r_read_w   <= 1'b1;
                            r_read_hw  <= 1'b0;
                            r_read_req <= 1'b1;
                            r_state    <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (read_valid || w_timeout) begin
                        if (r_own_d) begin
                            r_d_valid <= 1'b1;
                            r_d_rdata <= read_valid ? read_data : 32'd0;
                        end else begin
                            r_if_valid <= 1'b1;
                            r_if_data  <= read_valid ? read_data : 32'd0;
                        end
                        r_err   <= ~read_valid;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                WR_WAIT: begin
                    if (write_finish || w_timeout) begin
                        r_d_finish <= 1'b1;
                        r_err      <= ~write_finish;
                        r_state    <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qspi_req_arb.sv
// tb_qspi_req_arb: directed checks of qspi_req_arb. u_dut uses the default
// timeout; u_dut_to uses TIMEOUT=8 for the timeout scenario.
module tb_qspi_req_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_adr;
    logic        d_rd_req, d_wr_req, d_w, d_hw;
    logic [31:0] d_adr, d_wdata;
    logic        read_valid;
    logic [31:0] read_data;
    logic        write_finish;

    logic        if_valid, d_valid, d_finish, err;
    logic [31:0] if_data, d_rdata;
    logic        read_req, read_w, read_hw, write_req, write_w, write_hw;
    logic [31:0] read_adr, write_adr, write_data;

    logic        if_valid_t, d_valid_t, d_finish_t, err_t;
    logic [31:0] if_data_t, d_rdata_t;
    logic        read_req_t, read_w_t, read_hw_t, write_req_t, write_w_t, write_hw_t;
    logic [31:0] read_adr_t, write_adr_t, write_data_t;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    qspi_req_arb u_dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_adr(if_adr), .if_valid(if_valid), .if_data(if_data),
        .d_rd_req(d_rd_req), .d_wr_req(d_wr_req), .d_w(d_w), .d_hw(d_hw),
        .d_adr(d_adr), .d_wdata(d_wdata), .d_valid(d_valid), .d_rdata(d_rdata),
        .d_finish(d_finish), .err(err),
        .read_req(read_req), .read_w(read_w), .read_hw(read_hw), .read_adr(read_adr),
        .read_valid(read_valid), .read_data(read_data),
        .write_req(write_req), .write_w(write_w), .write_hw(write_hw),
        .write_adr(write_adr), .write_data(write_data), .write_finish(write_finish)
    );

    qspi_req_arb #(.TIMEOUT(8)) u_dut_to (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_adr(if_adr), .if_valid(if_valid_t), .if_data(if_data_t),
        .d_rd_req(d_rd_req), .d_wr_req(d_wr_req), .d_w(d_w), .d_hw(d_hw),
        .d_adr(d_adr), .d_wdata(d_wdata), .d_valid(d_valid_t), .d_rdata(d_rdata_t),
        .d_finish(d_finish_t), .err(err_t),
        .read_req(read_req_t), .read_w(read_w_t), .read_hw(read_hw_t), .read_adr(read_adr_t),
        .read_valid(read_valid), .read_data(read_data),
        .write_req(write_req_t), .write_w(write_w_t), .write_hw(write_hw_t),
        .write_adr(write_adr_t), .write_data(write_data_t), .write_finish(write_finish)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // bundle of every output of the default-timeout instance; zero means all quiet
    function automatic logic [31:0] all_out_or();
        return if_data | d_rdata | read_adr | write_adr | write_data |
               {24'd0, if_valid, d_valid, d_finish, err, read_req, read_w, read_hw,
                write_req | write_w | write_hw};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_adr;
        logic        exp_d;

        rst_n = 1'b0; if_req = 1'b0; if_adr = '0;
        d_rd_req = 1'b0; d_wr_req = 1'b0; d_w = 1'b0; d_hw = 1'b0;
        d_adr = '0; d_wdata = '0; read_valid = 1'b0; read_data = '0; write_finish = 1'b0;
        tick(); tick();
        chk("reset_outputs", all_out_or(), 32'd0);
        chk("reset_err_t", {31'd0, err_t}, 32'd0);
        rst_n = 1'b1;
        tick();

        // single fetch, 10-cycle downstream latency
        if_req = 1'b1; if_adr = 32'h0000_0100;
        tick();
        chk("f_read_req", {31'd0, read_req}, 32'd1);
        chk("f_read_adr", read_adr, 32'h100);
        chk("f_read_w_hw", {30'd0, read_w, read_hw}, 32'b10);
        tick();
        chk("f_read_req_1cyc", {31'd0, read_req}, 32'd0);
        for (int i = 0; i < 8; i++) tick();
        chk("f_no_early_valid", {31'd0, if_valid}, 32'd0);
        read_valid = 1'b1; read_data = 32'h1234_5678;
        tick();
        read_valid = 1'b0;
        chk("f_if_valid", {31'd0, if_valid}, 32'd1);
        chk("f_if_data", if_data, 32'h1234_5678);
        chk("f_err", {31'd0, err}, 32'd0);
        tick();
        chk("f_no_regrant_on_pulse", {31'd0, read_req}, 32'd0);
        chk("f_if_valid_1cyc", {31'd0, if_valid}, 32'd0);
        if_req = 1'b0;
        tick();

        // halfword data write
        d_wr_req = 1'b1; d_hw = 1'b1; d_adr = 32'h202; d_wdata = 32'hBEEF;
        tick();
        chk("w_write_req", {31'd0, write_req}, 32'd1);
        chk("w_write_w_hw", {30'd0, write_w, write_hw}, 32'b01);
        chk("w_write_adr", write_adr, 32'h202);
        chk("w_write_data", write_data, 32'hBEEF);
        chk("w_no_read_req", {31'd0, read_req}, 32'd0);
        tick();
        chk("w_write_req_1cyc", {31'd0, write_req}, 32'd0);
        write_finish = 1'b1;
        tick();
        write_finish = 1'b0;
        chk("w_d_finish", {31'd0, d_finish}, 32'd1);
        chk("w_err", {31'd0, err}, 32'd0);
        d_wr_req = 1'b0; d_hw = 1'b0;
        tick();
        chk("w_d_finish_1cyc", {31'd0, d_finish}, 32'd0);

        // round-robin contention from reset: D, F, D, F
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        if_req = 1'b1; if_adr = 32'h400;
        d_rd_req = 1'b1; d_w = 1'b1; d_adr = 32'h300;
        for (int k = 0; k < 4; k++) begin
            exp_d   = (k % 2 == 0);
            exp_adr = exp_d ? 32'h300 : 32'h400;
            tick();
            chk($sformatf("rr%0d_read_req", k), {31'd0, read_req}, 32'd1);
            chk($sformatf("rr%0d_read_adr", k), read_adr, exp_adr);
            tick();
            read_valid = 1'b1; read_data = 32'hA000_0000 + 32'(k + 1);
            tick();
            read_valid = 1'b0;
            chk($sformatf("rr%0d_valids", k), {30'd0, d_valid, if_valid},
                exp_d ? 32'b10 : 32'b01);
            chk($sformatf("rr%0d_data", k), exp_d ? d_rdata : if_data,
                32'hA000_0000 + 32'(k + 1));
            tick();
            chk($sformatf("rr%0d_gap", k), {31'd0, read_req}, 32'd0);
        end
        if_req = 1'b0; d_rd_req = 1'b0; d_w = 1'b0;
        tick();

        // timeout on the TIMEOUT=8 instance (d_rdata_t holds 0xA0000003 beforehand)
        d_rd_req = 1'b1; d_adr = 32'h800;
        tick();
        chk("to_read_req", {31'd0, read_req_t}, 32'd1);
        for (int i = 0; i < 8; i++) tick();
        chk("to_not_yet", {30'd0, d_valid_t, err_t}, 32'd0);
        tick();
        chk("to_d_valid_err", {30'd0, d_valid_t, err_t}, 32'b11);
        chk("to_d_rdata", d_rdata_t, 32'd0);
        d_rd_req = 1'b0;
        tick();
        chk("to_pulse_1cyc", {30'd0, d_valid_t, err_t}, 32'd0);
        read_valid = 1'b1; read_data = 32'h5555_AAAA;
        tick();
        read_valid = 1'b0;
        chk("to_stray_ignored", {30'd0, d_valid_t, err_t}, 32'd0);
        chk("to_noabort_default", {31'd0, d_valid}, 32'd1);
        tick();

        // simultaneous read and write request -> write
        d_rd_req = 1'b1; d_wr_req = 1'b1; d_w = 1'b1; d_adr = 32'h500; d_wdata = 32'h0BAD_F00D;
        tick();
        chk("rw_write_req", {31'd0, write_req}, 32'd1);
        chk("rw_read_req", {31'd0, read_req}, 32'd0);
        chk("rw_write_w", {30'd0, write_w, write_hw}, 32'b10);
        tick();
        chk("rw_read_req_later", {31'd0, read_req}, 32'd0);
        write_finish = 1'b1;
        tick();
        write_finish = 1'b0;
        chk("rw_d_finish", {31'd0, d_finish}, 32'd1);
        d_rd_req = 1'b0; d_wr_req = 1'b0; d_w = 1'b0;
        tick();

        // reset during RD_WAIT, late response ignored, next request served
        if_req = 1'b1; if_adr = 32'h600;
        tick();
        chk("rst_read_req", {31'd0, read_req}, 32'd1);
        tick();
        rst_n = 1'b0;
        tick();
        chk("rst_all_zero", all_out_or(), 32'd0);
        rst_n = 1'b1; if_req = 1'b0;
        read_valid = 1'b1; read_data = 32'hDEAD_BEEF;
        tick();
        read_valid = 1'b0;
        chk("rst_late_ignored", {30'd0, if_valid, d_valid}, 32'd0);
        if_req = 1'b1; if_adr = 32'h700;
        tick();
        chk("rst_next_req", {31'd0, read_req}, 32'd1);
        chk("rst_next_adr", read_adr, 32'h700);
        tick();
        read_valid = 1'b1; read_data = 32'hCAFE_F00D;
        tick();
        read_valid = 1'b0;
        chk("rst_next_valid", {31'd0, if_valid}, 32'd1);
        chk("rst_next_data", if_data, 32'hCAFE_F00D);
        if_req = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
